uart_tx_cfg: RTL

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 22 ++
 rtl/baud_tick.sv | 27 ++
 rtl/uart_tx_cfg.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM state
// encoding, parity mode codes and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // data_xor is the XOR of all data bits; odd parity inverts it.
  function automatic logic parity_bit(input logic data_xor, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: counts 0..BAUD_DIV-1, flags the last cycle of each
// period, and restarts at 0 whenever the transmitter changes state.
module baud_tick #(
  parameter int unsigned BAUD_DIV = 217
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = $clog2(BAUD_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(BAUD_DIV - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      cnt <= '0;
    else if (restart || tick)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-word holding register in front
// of the shift register; frames run back to back while words are queued.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = 217,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 ready,
  output logic                 tdre,
  output logic                 TxD,
  output logic                 busy,
  output logic                 ovr
);

  if (BAUD_DIV < 2 || BAUD_DIV > 65535) begin : g_bad_baud_div
    $error("uart_tx_cfg: BAUD_DIV must be in 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  state_t               state, state_n;
  logic [DATA_BITS-1:0] hold, hold_n;
  logic                 hold_full, hold_full_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [BW-1:0]        bitcnt, bitcnt_n;
  logic                 stopcnt, stopcnt_n;
  logic                 par, par_n;
  logic                 txd_r, txd_n;
  logic                 ovr_n;
  logic                 accept, xfer;
  logic                 tick, restart;

  assign tdre   = ~hold_full;
  assign busy   = (state != ST_IDLE);
  assign TxD    = txd_r;
  assign accept = ready & ~hold_full;
  assign ovr_n  = ready & hold_full;
  // Timer restarts on every state entry, including STOP->START reloads.
  assign restart = (state == ST_IDLE) || (state_n != state);

  baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk    (clk),
    .clr    (clr),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bitcnt_n  = bitcnt;
    stopcnt_n = stopcnt;
    par_n     = par;
    xfer      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (hold_full)
          xfer = 1'b1;
      end
      ST_START: begin
        if (tick) begin
          state_n  = ST_DATA;
          bitcnt_n = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_n = shreg >> 1;
          if (bitcnt == BW'(DATA_BITS - 1)) begin
            state_n   = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
            stopcnt_n = 1'b0;
          end else begin
            bitcnt_n = bitcnt + BW'(1);
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          state_n   = ST_STOP;
          stopcnt_n = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stopcnt == 1'(STOP_BITS - 1)) begin
            if (hold_full)
              xfer = 1'b1;
            else
              state_n = ST_IDLE;
          end else begin
            stopcnt_n = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A queued word starts its frame on the same edge the previous one ends.
    if (xfer) begin
      state_n = ST_START;
      shreg_n = hold;
      par_n   = parity_bit(^hold, PARITY);
    end

    hold_n      = accept ? tx_data : hold;
    hold_full_n = accept ? 1'b1 : (xfer ? 1'b0 : hold_full);

    // Line level is computed for the upcoming state so TxD leaves a flop.
    unique case (state_n)
      ST_START: txd_n = 1'b0;
      ST_DATA:  txd_n = shreg_n[0];
      ST_PAR:   txd_n = par_n;
      default:  txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= ST_IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      bitcnt    <= '0;
      stopcnt   <= 1'b0;
      par       <= 1'b0;
      txd_r     <= 1'b1;
      ovr       <= 1'b0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      shreg     <= shreg_n;
      bitcnt    <= bitcnt_n;
      stopcnt   <= stopcnt_n;
      par       <= par_n;
      txd_r     <= txd_n;
      ovr       <= ovr_n;
    end
  end

endmodule
